// File: rtl/crop_pkg.sv
// Shared types and cfg-word layout for the crop window stream.
// The cfg word packs {H, W, Y1, X1}, with X1 in the LSBs.
package crop_pkg;

  typedef enum logic {
    CFG    = 1'b0,
    STREAM = 1'b1
  } crop_state_e;

  localparam int unsigned DEF_ROW_W  = 10;
  localparam int unsigned DEF_COL_W  = 10;
  localparam int unsigned CFG_X1_LSB = 0;

  // X1 and W are column-wide fields; Y1 and H are row-wide fields.
  function automatic int unsigned cfg_y1_lsb(input int unsigned col_w);
    return col_w;
  endfunction

  function automatic int unsigned cfg_w_lsb(input int unsigned row_w, input int unsigned col_w);
    return col_w + row_w;
  endfunction

  function automatic int unsigned cfg_h_lsb(input int unsigned row_w, input int unsigned col_w);
    return 2 * col_w + row_w;
  endfunction

  function automatic int unsigned cfg_width(input int unsigned row_w, input int unsigned col_w);
    return 2 * (row_w + col_w);
  endfunction

endpackage

// File: rtl/crop_fifo_mem.sv
// First-word-fall-through FIFO: pointers, occupancy level, combinational head read.
module crop_fifo_mem #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  // A full FIFO refuses pushes even if a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/crop_window_stream.sv
// Crops a raster pixel stream to a configured window and buffers the result.
// Optional macro CROP_TLAST_EN adds pixel_out_TLAST on the last in-window beat.
module crop_window_stream
  import crop_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH  = 12,
  parameter int unsigned NUM_CHANNELS     = 1,
  parameter int unsigned IN_ROWS          = 40,
  parameter int unsigned IN_COLS          = 40,
  parameter int unsigned IMG_ROW_BITWIDTH = DEF_ROW_W,
  parameter int unsigned IMG_COL_BITWIDTH = DEF_COL_W,
  parameter int unsigned FIFO_DEPTH       = 256
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [PIXEL_BIT_WIDTH*NUM_CHANNELS-1:0]         pixel_in_TDATA,
  input  logic                                            pixel_in_TVALID,
  output logic                                            pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH*NUM_CHANNELS-1:0]         pixel_out_TDATA,
  output logic                                            pixel_out_TVALID,
  input  logic                                            pixel_out_TREADY,
`ifdef CROP_TLAST_EN
  output logic                                            pixel_out_TLAST,
`endif
  input  logic [2*(IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH)-1:0] cfg_TDATA,
  input  logic                                            cfg_TVALID,
  output logic                                            cfg_TREADY,
  output logic                                            busy,
  output logic [$clog2(FIFO_DEPTH):0]                     fifo_level
);

  localparam int unsigned PW     = PIXEL_BIT_WIDTH * NUM_CHANNELS;
  localparam int unsigned RW     = IMG_ROW_BITWIDTH;
  localparam int unsigned CW     = IMG_COL_BITWIDTH;
  localparam int unsigned Y1_LSB = cfg_y1_lsb(CW);
  localparam int unsigned W_LSB  = cfg_w_lsb(RW, CW);
  localparam int unsigned H_LSB  = cfg_h_lsb(RW, CW);
`ifdef CROP_TLAST_EN
  localparam int unsigned FW     = PW + 1;
`else
  localparam int unsigned FW     = PW;
`endif

  crop_state_e   state_q, state_d;
  logic [RW-1:0] row_q, row_d, y1_q, y1_d, h_q, h_d;
  logic [CW-1:0] col_q, col_d, x1_q, x1_d, w_q, w_d;

  logic [CW:0]   col_x, x_lo, x_hi;
  logic [RW:0]   row_x, y_lo, y_hi;
  logic          in_win, fifo_full, fifo_empty, fifo_push;
  logic [FW-1:0] fifo_wdata, fifo_rdata;

  // Window bounds carry one extra bit so X1+W and Y1+H cannot wrap.
  assign col_x  = {1'b0, col_q};
  assign row_x  = {1'b0, row_q};
  assign x_lo   = {1'b0, x1_q};
  assign y_lo   = {1'b0, y1_q};
  assign x_hi   = {1'b0, x1_q} + {1'b0, w_q};
  assign y_hi   = {1'b0, y1_q} + {1'b0, h_q};
  assign in_win = (col_x >= x_lo) && (col_x < x_hi) && (row_x >= y_lo) && (row_x < y_hi);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CFG;
      row_q   <= '0;
      col_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      w_q     <= w_d;
      h_q     <= h_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_d           = col_q;
    x1_d            = x1_q;
    y1_d            = y1_q;
    w_d             = w_q;
    h_d             = h_q;
    cfg_TREADY      = 1'b0;
    pixel_in_TREADY = 1'b0;
    fifo_push       = 1'b0;
    case (state_q)
      CFG: begin
        cfg_TREADY = 1'b1;
        if (cfg_TVALID) begin
          x1_d    = cfg_TDATA[CFG_X1_LSB +: CW];
          y1_d    = cfg_TDATA[Y1_LSB +: RW];
          w_d     = cfg_TDATA[W_LSB +: CW];
          h_d     = cfg_TDATA[H_LSB +: RW];
          row_d   = '0;
          col_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Out-of-window beats are dropped, so only in-window beats see backpressure.
        pixel_in_TREADY = !in_win || !fifo_full;
        if (pixel_in_TVALID && pixel_in_TREADY) begin
          fifo_push = in_win;
          if (col_q == CW'(IN_COLS - 1)) begin
            col_d = '0;
            if (row_q == RW'(IN_ROWS - 1)) begin
              row_d   = '0;
              state_d = CFG;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = CFG;
    endcase
  end

`ifdef CROP_TLAST_EN
  logic [CW:0] col_end;
  logic [RW:0] row_end;
  logic        last_beat;

  // Clipped window end; the last in-window beat sits just before it on both axes.
  assign col_end   = (x_hi < (CW+1)'(IN_COLS)) ? x_hi : (CW+1)'(IN_COLS);
  assign row_end   = (y_hi < (RW+1)'(IN_ROWS)) ? y_hi : (RW+1)'(IN_ROWS);
  assign last_beat = in_win && (col_x + (CW+1)'(1) == col_end) && (row_x + (RW+1)'(1) == row_end);
  assign fifo_wdata = {last_beat, pixel_in_TDATA};
  assign {pixel_out_TLAST, pixel_out_TDATA} = fifo_rdata;
`else
  assign fifo_wdata      = pixel_in_TDATA;
  assign pixel_out_TDATA = fifo_rdata;
`endif

  crop_fifo_mem #(
    .DATA_W (FW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (pixel_out_TREADY),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign pixel_out_TVALID = !fifo_empty;
  assign busy             = (state_q == STREAM) || !fifo_empty;

endmodule

// File: tb/tb_crop_window_stream.sv
// Directed bench for crop_window_stream with a queue-based window model.
// Builds with or without CROP_TLAST_EN.
module tb_crop_window_stream;

  localparam int unsigned PBW   = 12;
  localparam int unsigned NCH   = 3;
  localparam int unsigned ROWS  = 40;
  localparam int unsigned COLS  = 40;
  localparam int unsigned RW    = 10;
  localparam int unsigned CW    = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = PBW * NCH;
  localparam int unsigned CFGW  = 2 * (RW + CW);
  localparam int unsigned LW    = $clog2(DEPTH) + 1;
  localparam int          NPIX  = ROWS * COLS;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DW-1:0]   pixel_in_TDATA = '0;
  logic            pixel_in_TVALID = 1'b0;
  logic            pixel_in_TREADY;
  logic [DW-1:0]   pixel_out_TDATA;
  logic            pixel_out_TVALID;
  logic            pixel_out_TREADY = 1'b0;
`ifdef CROP_TLAST_EN
  logic            pixel_out_TLAST;
`endif
  logic [CFGW-1:0] cfg_TDATA = '0;
  logic            cfg_TVALID = 1'b0;
  logic            cfg_TREADY;
  logic            busy;
  logic [LW-1:0]   fifo_level;

  crop_window_stream #(
    .PIXEL_BIT_WIDTH (PBW),
    .NUM_CHANNELS    (NCH),
    .IN_ROWS         (ROWS),
    .IN_COLS         (COLS),
    .IMG_ROW_BITWIDTH(RW),
    .IMG_COL_BITWIDTH(CW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in_TDATA  (pixel_in_TDATA),
    .pixel_in_TVALID (pixel_in_TVALID),
    .pixel_in_TREADY (pixel_in_TREADY),
    .pixel_out_TDATA (pixel_out_TDATA),
    .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY),
`ifdef CROP_TLAST_EN
    .pixel_out_TLAST (pixel_out_TLAST),
`endif
    .cfg_TDATA       (cfg_TDATA),
    .cfg_TVALID      (cfg_TVALID),
    .cfg_TREADY      (cfg_TREADY),
    .busy            (busy),
    .fifo_level      (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            m_x1, m_y1, m_w, m_h, m_k;
  bit            m_active = 1'b0;
  int            out_cnt = 0, last_cnt = 0, last_pos = -1;
  logic [DW-1:0] first_data, last_data, prev_data;
  bit            prev_stall = 1'b0;
  bit            exp_in_ready;
  exp_t          popped;
  int            valid_pct = 100;
  int            ready_pct = 100;
  int            drv_k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Ramp frame: channel c of beat k carries (k + 1000*c) mod 4096.
  function automatic logic [DW-1:0] ramp(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) r[c*PBW +: PBW] = PBW'((k + c * 1000) % 4096);
    return r;
  endfunction

  function automatic bit inwin(input int k);
    int r, c;
    r = k / COLS;
    c = k % COLS;
    return (c >= m_x1) && (c < m_x1 + m_w) && (r >= m_y1) && (r < m_y1 + m_h);
  endfunction

  // Raster index of the last in-window beat after clipping, -1 when the window is empty.
  function automatic int last_index();
    int re, ce;
    re = (m_y1 + m_h < ROWS) ? m_y1 + m_h : ROWS;
    ce = (m_x1 + m_w < COLS) ? m_x1 + m_w : COLS;
    if (re <= m_y1 || ce <= m_x1) return -1;
    return (re - 1) * COLS + (ce - 1);
  endfunction

  // Model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_active   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      exp_in_ready = m_active && (!inwin(m_k) || exp_q.size() < DEPTH);
      check("cfg_TREADY", 64'(cfg_TREADY), 64'(!m_active));
      check("pixel_in_TREADY", 64'(pixel_in_TREADY), 64'(exp_in_ready));
      check("pixel_out_TVALID", 64'(pixel_out_TVALID), 64'(exp_q.size() != 0));
      check("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
      check("busy", 64'(busy), 64'(m_active || exp_q.size() != 0));
      if (prev_stall && pixel_out_TVALID) check("TDATA_hold", 64'(pixel_out_TDATA), 64'(prev_data));
      if (exp_q.size() != 0) begin
        check("TDATA", 64'(pixel_out_TDATA), 64'(exp_q[0].data));
`ifdef CROP_TLAST_EN
        check("TLAST", 64'(pixel_out_TLAST), 64'(exp_q[0].last));
`endif
      end
      prev_stall = pixel_out_TVALID && !pixel_out_TREADY;
      prev_data  = pixel_out_TDATA;
      if (exp_q.size() != 0 && pixel_out_TREADY) begin
        popped = exp_q.pop_front();
        out_cnt++;
        if (out_cnt == 1) first_data = popped.data;
        last_data = popped.data;
        if (popped.last) begin
          last_cnt++;
          last_pos = out_cnt;
        end
      end
      if (m_active && pixel_in_TVALID && exp_in_ready) begin
        if (inwin(m_k)) exp_q.push_back('{last: (m_k == last_index()), data: ramp(m_k)});
        m_k++;
        if (m_k == NPIX) m_active = 1'b0;
      end else if (!m_active && cfg_TVALID) begin
        m_x1     = int'(cfg_TDATA[0 +: CW]);
        m_y1     = int'(cfg_TDATA[CW +: RW]);
        m_w      = int'(cfg_TDATA[CW+RW +: CW]);
        m_h      = int'(cfg_TDATA[2*CW+RW +: RW]);
        m_active = 1'b1;
        m_k      = 0;
        out_cnt  = 0;
        last_cnt = 0;
        last_pos = -1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pixel_out_TREADY = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic send_cfg(input int x1, input int y1, input int w, input int h);
    bit acc;
    acc = 1'b0;
    cfg_TDATA  = {RW'(h), CW'(w), RW'(y1), CW'(x1)};
    cfg_TVALID = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = cfg_TREADY;
      @(posedge clk);
      #1;
    end
    cfg_TVALID = 1'b0;
    check("cfg_accept", 64'(acc), 64'd1);
    drv_k = 0;
  endtask

  task automatic run_frame(input int until_k, input int max_cyc, output bit done);
    int cyc;
    cyc = 0;
    while (drv_k < until_k && cyc < max_cyc) begin
      pixel_in_TVALID = ($urandom_range(0, 99) < valid_pct);
      pixel_in_TDATA  = ramp(drv_k);
      @(negedge clk);
      if (pixel_in_TVALID && pixel_in_TREADY) drv_k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    pixel_in_TVALID = 1'b0;
    done = (drv_k >= until_k);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic frame(input int x1, input int y1, input int w, input int h, input int exp_cnt);
    bit done;
    send_cfg(x1, y1, w, h);
    run_frame(NPIX, 20000, done);
    check("frame_done", 64'(done), 64'd1);
    wait_idle(5000);
    check("out_count", 64'(out_cnt), 64'(exp_cnt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(pixel_out_TVALID), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_in_ready"}, 64'(pixel_in_TREADY), 64'd0);
    check({tag, "_cfg_ready"}, 64'(cfg_TREADY), 64'd1);
  endtask

  initial begin
    bit done;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("released");

    // Centred 20x20 window on the ramp frame.
    frame(10, 10, 20, 20, 400);
    check("t1_first", 64'(first_data), 64'h96A58219A);
    check("t1_last", 64'(last_data), 64'hC7588D4A5);

    // Clipped on the right edge: 10 beats per row over 5 rows.
    frame(30, 0, 20, 5, 50);
    check("t2_first", 64'(first_data), 64'h7EE40601E);
    check("t2_last", 64'(last_data), 64'h8974AF0C7);

    // Zero width: whole frame consumed, nothing emitted.
    frame(0, 0, 0, 10, 0);
    check("t3_cfg_ready", 64'(cfg_TREADY), 64'd1);

    // Output stalled: FIFO saturates, input blocks on the 17th in-window beat.
    send_cfg(10, 10, 20, 20);
    ready_pct = 0;
    run_frame(NPIX, 700, done);
    check("t4_stall_k", 64'(drv_k), 64'd426);
    check("t4_level_full", 64'(fifo_level), 64'd16);
    check("t4_in_blocked", 64'(pixel_in_TREADY), 64'd0);
    ready_pct = 100;
    run_frame(NPIX, 20000, done);
    check("t4_done", 64'(done), 64'd1);
    wait_idle(5000);
    check("t4_out_count", 64'(out_cnt), 64'd400);

    // Random valid/ready gaps.
    valid_pct = 70;
    ready_pct = 60;
    frame(5, 3, 7, 4, 28);
    valid_pct = 100;

    // Reset mid-frame at beat 500.
    ready_pct = 50;
    send_cfg(0, 0, 40, 40);
    run_frame(500, 5000, done);
    check("t6_reached_500", 64'(done), 64'd1);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs("midframe");
    @(posedge clk);
    #1 reset = 1'b1;
    ready_pct = 100;
    frame(1, 2, 2, 2, 4);
    check("t6_first", 64'(first_data), 64'h821439051);
`ifdef CROP_TLAST_EN
    check("t6_tlast_count", 64'(last_cnt), 64'd1);
    check("t6_tlast_pos", 64'(last_pos), 64'd4);
`endif

    // Window overhanging the bottom-right corner.
    frame(38, 38, 5, 5, 4);
    check("t7_last", 64'(last_data), 64'hE0FA2763F);
`ifdef CROP_TLAST_EN
    check("t7_tlast_pos", 64'(last_pos), 64'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/crop_window_stream.md
CROP_WINDOW_STREAM -- requirements
Module: crop_window_stream

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 12, the bits per channel sample.
REQ-002 SHALL have parameter NUM_CHANNELS, default 1, the number of channel samples packed per beat (channel 0 in the LSBs).
REQ-003 SHALL have parameters IN_ROWS / IN_COLS, default 40 / 40, the input frame dimensions.
REQ-004 SHALL have parameters IMG_ROW_BITWIDTH / IMG_COL_BITWIDTH, default 10 / 10, the coordinate widths.
REQ-005 SHALL have parameter FIFO_DEPTH, default 256, the output buffer entries (power of 2, >=2).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have ports pixel_in_TDATA / TVALID / TREADY, in / in / out, PIXEL_BIT_WIDTH*NUM_CHANNELS / 1 / 1 bits, the input pixel stream.
REQ-009 SHALL have ports pixel_out_TDATA / TVALID / TREADY, out / out / in, same widths, the cropped stream.
REQ-010 SHALL have ports cfg_TDATA / TVALID / TREADY, in / in / out, 2*(IMG_ROW_BITWIDTH+IMG_COL_BITWIDTH) / 1 / 1 bits, packed {H,W,Y1,X1} with X1 in the LSBs.
REQ-011 SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits, the current buffer occupancy.

Function
REQ-013 SHALL implement an FSM with states CFG and STREAM.
REQ-014 In CFG: cfg_TREADY=1 and pixel_in_TREADY=0; a cfg handshake latches X1,Y1,W,H and moves to STREAM on the next cycle.
REQ-015 In STREAM: cfg_TREADY=0; the FSM returns to CFG the cycle after input beat IN_ROWS*IN_COLS is accepted.
REQ-016 Row/col counters SHALL be raster order, col wrapping IN_COLS-1 -> 0 with row incrementing, both cleared on entering STREAM.
REQ-017 A beat is inside the window iff X1<=col<X1+W and Y1<=row<Y1+H; comparisons use widths +1 bit so there is no overflow.
REQ-018 A window extending past the image edge SHALL be clipped; W=0 or H=0 consumes the frame with zero output beats.
REQ-019 In STREAM: pixel_in_TREADY = outside-window OR fifo not full; outside-window beats are discarded without stalling.
REQ-020 Full FIFO SHALL block push even when a pop occurs in the same cycle (no ready combinational path out->in).
REQ-021 Simultaneous push and pop when not full and not empty SHALL leave fifo_level unchanged.
REQ-022 The FIFO SHALL be first-word-fall-through: a beat pushed in cycle N is valid on pixel_out in cycle N+1 when the FIFO was empty.
REQ-023 pixel_out_TVALID=!empty; TDATA is held stable while TVALID && !TREADY.
REQ-024 busy = (state==STREAM) OR !empty.
REQ-025 Output order SHALL equal input raster order of in-window beats; channels are never reordered.

Reset
REQ-026 reset low SHALL immediately force state=CFG, counters=0, FIFO empty, latched window=0, pixel_out_TVALID=0, busy=0, fifo_level=0, pixel_in_TREADY=0, cfg_TREADY=1 after release.
REQ-027 Reset mid-frame SHALL discard buffered data; the next frame requires a new cfg handshake.

Configuration
REQ-028 Macro CROP_TLAST_EN, when defined, SHALL add output pixel_out_TLAST, asserted with the last in-window beat of a frame; when W or H is 0 no TLAST is produced.
REQ-029 Without CROP_TLAST_EN the port and its FIFO storage bit SHALL be absent.

Structure
REQ-030 Package crop_pkg SHALL hold the FSM state typedef (CFG, STREAM) and the cfg field offset/width constants.
REQ-031 Storage SHALL be sub-module crop_fifo_mem (pointers, level, FWFT read), instantiated once.

Verification
REQ-032 Cfg X1=10,Y1=10,W=20,H=20 on a 40x40 ramp frame with TREADY=1 -> 400 beats matching the ramp in the window, in raster order; busy drops after drain.
REQ-033 Cfg X1=30,W=20 -> 10 beats per row (clipping); W=0 -> 0 beats, FSM returns to CFG after 1600 inputs.
REQ-034 pixel_out_TREADY=0 with FIFO_DEPTH=16 -> fifo_level saturates at 16, pixel_in_TREADY=0 only on in-window beats, no loss after release.
REQ-035 NUM_CHANNELS=3, random TVALID/TREADY gaps -> packed output equals the model; TDATA stable while stalled.
REQ-036 reset asserted mid-frame at beat 500 -> outputs at reset values asynchronously; a new cfg plus frame produces the correct output.
REQ-037 With CROP_TLAST_EN, cfg W=H=2 -> TLAST only on the 4th output beat.
